mem_write_checker: RTL
======================

# mem_write_checker

Synthesizable, parametrised memory-write checker that sits beside the pipelined MIPS `top` on its data-memory write port (`memwrite`, `dataadr`, `writedata`). It compares every write inside a programmable address window against a loaded table of expected (address, data) pairs in order. It flags pass, fail or timeout in hardware, with captured error context. Benches and on-board self-tests use it instead of hand-written negedge `$display` checks.

## Interface
Parameters:
- DATA_W, 32, width of `writedata` and expected data
- ADDR_W, 32, width of `dataadr` and expected address
- DEPTH, 8, number of expected-write table entries; IDX_W = $clog2(DEPTH)
- CNT_W, 16, width of write counter and timeout counter
- TIMEOUT, 1024, cycles allowed in ARMED without an in-window write; 0 disables timeout

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets the block)
- cfg_we  in  1  write table entry `cfg_idx`; honoured only in IDLE
- cfg_idx  in  IDX_W  table entry index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- cfg_len  in  IDX_W+1  number of valid entries; sampled on arm; values above DEPTH clamp to DEPTH
- win_lo, win_hi  in  ADDR_W  inclusive check window; sampled on arm
- arm  in  1  start or restart a check
- clear  in  1  return to IDLE
- memwrite  in  1  DUT write strobe
- dataadr  in  ADDR_W  DUT write address
- writedata  in  DATA_W  DUT write data
- state  out  2  IDLE=0, ARMED=1, PASS=2, FAIL=3
- done  out  1  state is PASS or FAIL
- pass, fail  out  1  state flags
- exp_idx  out  IDX_W+1  next table entry expected
- wr_count  out  CNT_W  writes seen in ARMED (all addresses), saturating
- err_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
- err_idx  out  IDX_W+1  exp_idx at failure
- err_addr, err_data  out  ADDR_W/DATA_W  offending write; 0 on timeout

## Operation
- Reset: state IDLE. All outputs 0, counters 0. Table contents are not reset; they are don't-care until loaded.
- IDLE: `cfg_we` writes the table. `arm` with clamped cfg_len>0 latches len/win_lo/win_hi, clears counters and error fields, and enters ARMED. `arm` with len==0 is ignored.
- ARMED, at each edge with memwrite=1:
  - wr_count increments and saturates at all-ones.
  - If win_lo <= dataadr <= win_hi (unsigned), compare against table[exp_idx]:
    - Address differs: FAIL, err_code=1.
    - Address matches, data differs: FAIL, err_code=2.
    - Both match: exp_idx increments. When the new exp_idx equals len: PASS.
  - Out-of-window writes affect only wr_count.
- Timeout counter:
  - Counts ARMED cycles since arm or since the last in-window write. Resets to 0 on each in-window write.
  - When TIMEOUT!=0 and the count reaches TIMEOUT: FAIL with err_code=3, err_addr=0, err_data=0.
- On FAIL, err_idx, err_addr and err_data are captured. All fields hold until the next arm, clear or reset.
- PASS and FAIL are sticky. Further memwrite activity changes nothing, including wr_count.
- `arm` in ARMED, PASS or FAIL restarts the check with fresh counters. `clear` in any state goes to IDLE and zeroes counters and errors.
- Priority per edge: reset > clear > arm > memwrite evaluation.

## Timing
- All outputs are registered. A write sampled at edge N produces its state, exp_idx and err_* updates visible after edge N (1-cycle latency).
- A write in the same cycle as the arm that leaves IDLE is not checked. A write in the same cycle as a restart-arm is also discarded.
- Timeout: with arm at edge 0 and no in-window writes, FAIL is asserted after edge TIMEOUT.
- `cfg_we` in the cycle `arm` is taken is applied before the arm latches.
- Reset or clear mid-ARMED aborts without raising `done`.

## Structure
- Package `mem_chk_pkg` holds:
  - enum `chk_state_t` (IDLE, ARMED, PASS, FAIL)
  - enum `chk_err_t` (NONE, ADDR, DATA, TIMEOUT)
  - helper function `in_window(addr, lo, hi)`
- Sub-module `mem_chk_table`: DEPTH×(ADDR_W+DATA_W) register file with one write port and one combinational read port indexed by exp_idx.
- The top-level module holds the FSM, counters and capture registers.

## Test plan
- Load (80,7),(84,7), cfg_len=2, window 0..255, arm. Writes 80/7 then 84/7 give PASS after the second write edge, with exp_idx=2, wr_count=2 and err_code=0.
- Same table, first write 80/5 gives FAIL with err_code=2, err_idx=0, err_addr=80, err_data=5. A following write 84/7 is ignored and wr_count stays 1.
- Window 64..127. Write 200/9, then 80/7, then 84/7. The 200/9 write is ignored except wr_count=1. Result is PASS with wr_count=3.
- TIMEOUT=16, arm, no writes: FAIL with err_code=3 after edge 16. A write 88/1 to table entry (80,7) gives FAIL with err_code=1.
- Drive reset=0 mid-ARMED after one match: all outputs return to 0. A re-arm after reload passes normally. Pulse clear and arm together: the block ends in IDLE.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// mem_chk_pkg: shared types and helpers for the memory-write checker.
//   chk_state_t : checker FSM state, encoding visible on the `state` port
//   chk_err_t   : failure cause, encoding visible on the `err_code` port
//   in_window   : inclusive unsigned address-window test
package mem_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } chk_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ADDR    = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } chk_err_t;

  // Widest address the window helper handles; callers zero-extend into it.
  localparam int MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] addr_max_t;

  function automatic logic in_window(addr_max_t addr, addr_max_t lo, addr_max_t hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/mem_chk_table.sv
// mem_chk_table: expected-write table, DEPTH entries of (address, data).
//   clk            : rising-edge clock
//   we/widx        : write enable and entry index
//   waddr/wdata    : expected address/data written to entry widx
//   ridx           : combinational read index
//   raddr/rdata    : expected address/data of entry ridx (0 if out of range)
// Contents are deliberately not reset.
module mem_chk_table #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(widx) < DEPTH)) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  always_comb begin
    raddr = '0;
    rdata = '0;
    if (int'(ridx) < DEPTH) begin
      raddr = addr_mem[ridx];
      rdata = data_mem[ridx];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks data-memory writes inside [win_lo, win_hi]
// against a loaded table of expected (address, data) pairs, in order.
//   clk, reset (sync, active-low)
//   cfg_we/cfg_idx/cfg_addr/cfg_data : table load, honoured in IDLE only
//   cfg_len, win_lo, win_hi          : sampled when arm is taken
//   arm, clear                       : start/restart, return to IDLE
//   memwrite/dataadr/writedata       : observed write port
//   state/done/pass/fail             : status
//   exp_idx, wr_count                : progress counters
//   err_code/err_idx/err_addr/err_data : failure context
module mem_write_checker
  import mem_chk_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int DEPTH   = 8,
  parameter  int CNT_W   = 16,
  parameter  int TIMEOUT = 1024,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_len,
  input  logic [ADDR_W-1:0] win_lo,
  input  logic [ADDR_W-1:0] win_hi,
  input  logic              arm,
  input  logic              clear,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic [1:0]        state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W:0]    exp_idx,
  output logic [CNT_W-1:0]  wr_count,
  output logic [1:0]        err_code,
  output logic [IDX_W:0]    err_idx,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data
);

  localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  chk_state_t        st_q, st_d;
  chk_err_t          errc_q, errc_d;
  logic [IDX_W:0]    idx_q, idx_d, len_q, len_d, erri_q, erri_d;
  logic [CNT_W-1:0]  wrc_q, wrc_d, tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, erra_q, erra_d;
  logic [DATA_W-1:0] errd_q, errd_d;

  logic [IDX_W:0]    len_clamped, idx_inc;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              hit, tmo_fire;

  mem_chk_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && (st_q == IDLE)),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (idx_q[IDX_W-1:0]),
    .raddr (tbl_addr),
    .rdata (tbl_data)
  );

  assign len_clamped = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign idx_inc     = idx_q + (IDX_W+1)'(1);
  assign hit         = in_window(addr_max_t'(dataadr), addr_max_t'(lo_q), addr_max_t'(hi_q));
  assign tmo_fire    = TMO_EN && (tcnt_q == TMO_LAST);

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    len_d  = len_q;
    wrc_d  = wrc_q;
    tcnt_d = tcnt_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    errc_d = errc_q;
    erri_d = erri_q;
    erra_d = erra_q;
    errd_d = errd_q;

    if (clear) begin
      st_d   = IDLE;
      idx_d  = '0;
      wrc_d  = '0;
      tcnt_d = '0;
      errc_d = ERR_NONE;
      erri_d = '0;
      erra_d = '0;
      errd_d = '0;
    end else if (arm && (len_clamped != '0)) begin
      // Restart from any state; a write in this cycle is not checked.
      st_d   = ARMED;
      len_d  = len_clamped;
      lo_d   = win_lo;
      hi_d   = win_hi;
      idx_d  = '0;
      wrc_d  = '0;
      tcnt_d = '0;
      errc_d = ERR_NONE;
      erri_d = '0;
      erra_d = '0;
      errd_d = '0;
    end else if (st_q == ARMED) begin
      if (memwrite && (wrc_q != '1)) begin
        wrc_d = wrc_q + CNT_W'(1);
      end
      if (memwrite && hit) begin
        tcnt_d = '0;
        if (dataadr != tbl_addr) begin
          st_d   = FAIL;
          errc_d = ERR_ADDR;
          erri_d = idx_q;
          erra_d = dataadr;
          errd_d = writedata;
        end else if (writedata != tbl_data) begin
          st_d   = FAIL;
          errc_d = ERR_DATA;
          erri_d = idx_q;
          erra_d = dataadr;
          errd_d = writedata;
        end else begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            st_d = PASS;
          end
        end
      end else if (tmo_fire) begin
        st_d   = FAIL;
        errc_d = ERR_TIMEOUT;
        erri_d = idx_q;
        erra_d = '0;
        errd_d = '0;
      end else begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      len_q  <= '0;
      wrc_q  <= '0;
      tcnt_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      errc_q <= ERR_NONE;
      erri_q <= '0;
      erra_q <= '0;
      errd_q <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      wrc_q  <= wrc_d;
      tcnt_q <= tcnt_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      errc_q <= errc_d;
      erri_q <= erri_d;
      erra_q <= erra_d;
      errd_q <= errd_d;
    end
  end

  assign state    = st_q;
  assign done     = (st_q == PASS) || (st_q == FAIL);
  assign pass     = (st_q == PASS);
  assign fail     = (st_q == FAIL);
  assign exp_idx  = idx_q;
  assign wr_count = wrc_q;
  assign err_code = errc_q;
  assign err_idx  = erri_q;
  assign err_addr = erra_q;
  assign err_data = errd_q;

endmodule
